// File: rtl/tlut_feed_ctrl_if.sv
// tlut_feed_ctrl_if: bundles the upstream job handshake, cell drive and result handshake.
// slave = the sequencer; master = upstream controller, consumer and cell.
interface tlut_feed_ctrl_if #(
  parameter int DIM_A        = 9,
  parameter int DIM_C        = 9,
  parameter int DIM_MULT     = 9,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 8
);
  localparam int IB_W = DIM_A * INPUT_WIDTH;
  localparam int WB_W = DIM_C * WEIGHT_WIDTH;
  localparam int PR_W = DIM_MULT * ACC_WIDTH;

  logic            in_valid;
  logic            in_ready;
  logic [IB_W-1:0] in_input_bin;
  logic [WB_W-1:0] in_weight_bin;

  logic            cell_rst_n;
  logic            cell_enable;
  logic [IB_W-1:0] cell_input_bin;
  logic [WB_W-1:0] cell_weight_bin;
  logic [PR_W-1:0] cell_product;

  logic            out_valid;
  logic            out_ready;
  logic [PR_W-1:0] out_product;

  logic            busy;
  logic [15:0]     job_cnt;

  modport slave (
    input  in_valid,
    input  in_input_bin,
    input  in_weight_bin,
    output in_ready,
    output cell_rst_n,
    output cell_enable,
    output cell_input_bin,
    output cell_weight_bin,
    input  cell_product,
    output out_valid,
    input  out_ready,
    output out_product,
    output busy,
    output job_cnt
  );

  modport master (
    output in_valid,
    output in_input_bin,
    output in_weight_bin,
    input  in_ready,
    input  cell_rst_n,
    input  cell_enable,
    input  cell_input_bin,
    input  cell_weight_bin,
    output cell_product,
    input  out_valid,
    output out_ready,
    input  out_product,
    input  busy,
    input  job_cnt
  );
endinterface

// File: rtl/tlut_feed_ctrl.sv
// tlut_feed_ctrl: sequences one simd_cell job: latch operands, clear, enable, settle, capture.
// Ports: clk, rst (async high), bus (slave view of tlut_feed_ctrl_if).
module tlut_feed_ctrl #(
  parameter int DIM_A          = 9,
  parameter int DIM_C          = 9,
  parameter int DIM_MULT       = 9,
  parameter int INPUT_WIDTH    = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int ACC_WIDTH      = 8,
  parameter int COMPUTE_CYCLES = 16,
  parameter int PIPE_LAT       = 2
) (
  input  logic             clk,
  input  logic             rst,
  tlut_feed_ctrl_if.slave  bus
);
  localparam int IB_W = DIM_A * INPUT_WIDTH;
  localparam int WB_W = DIM_C * WEIGHT_WIDTH;
  localparam int PR_W = DIM_MULT * ACC_WIDTH;

  localparam int CNT_MAX =
    (COMPUTE_CYCLES > PIPE_LAT) ? COMPUTE_CYCLES : PIPE_LAT;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [IB_W-1:0]  ib_q;
  logic [WB_W-1:0]  wb_q;
  logic [PR_W-1:0]  prod_q;
  logic [15:0]      job_cnt_q;
  logic             rst_done_q;
  logic             load;
  logic             capture;
  logic             retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_n   = '0;
          state_n = SETTLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == SET_LAST) begin
          cnt_n   = '0;
          capture = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          retire  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Operands persist until the next acceptance so the cell
  // sees stable inputs through DONE and IDLE as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ib_q       <= '0;
      wb_q       <= '0;
      prod_q     <= '0;
      job_cnt_q  <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (load) begin
        ib_q <= bus.in_input_bin;
        wb_q <= bus.in_weight_bin;
      end
      if (capture) begin
        prod_q <= bus.cell_product;
      end
      if (retire) begin
        job_cnt_q <= job_cnt_q + 16'd1;
      end
    end
  end

  // rst_done_q keeps the cell cleared while rst is high
  // without a combinational path from rst to the output.
  assign bus.cell_rst_n =
    rst_done_q & (state_q != CLEAR);

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.cell_enable     = (state_q == RUN);
  assign bus.out_valid       = (state_q == DONE);
  assign bus.cell_input_bin  = ib_q;
  assign bus.cell_weight_bin = wb_q;
  assign bus.out_product     = prod_q;
  assign bus.job_cnt         = job_cnt_q;
endmodule

// File: doc/tlut_feed_ctrl.md
# tlut_feed_ctrl

Operand sequencer that drives one `simd_cell` (TLUT multiplier with adder trees) as hardware rather than bench stimulus. It accepts an input/weight vector pair over a valid/ready handshake and holds the operands stable on the cell. It clears the cell accumulators, asserts `enable` for exactly one temporal compute window, waits for the adder-tree pipeline to settle, and then captures `product_acc`. The captured result is returned to the upstream controller over a second valid/ready handshake.

## Interface
- `DIM_A`, 9, number of input lanes
- `DIM_C`, 9, number of weight lanes
- `DIM_MULT`, 9, number of product lanes returned by the cell
- `INPUT_WIDTH`, 4, bits per input lane
- `WEIGHT_WIDTH`, 4, bits per weight lane
- `ACC_WIDTH`, 8, bits per product lane
- `COMPUTE_CYCLES`, 16 (= 2^INPUT_WIDTH), enable cycles per job; legal range is 1 or more
- `PIPE_LAT`, 2, settle cycles between the last enable cycle and capture; legal range is 1 or more
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: asynchronous, active-high reset
- `in_valid` input 1: operand pair offered
- `in_ready` output 1: block can accept a pair
- `in_input_bin` input DIM_A*INPUT_WIDTH: packed input vector, lane 0 in LSBs
- `in_weight_bin` input DIM_C*WEIGHT_WIDTH: packed weight vector, lane 0 in LSBs
- `cell_rst_n` output 1: active-low clear to the cell
- `cell_enable` output 1: cell enable
- `cell_input_bin` output DIM_A*INPUT_WIDTH: registered operands to the cell
- `cell_weight_bin` output DIM_C*WEIGHT_WIDTH: registered weights to the cell
- `cell_product` input DIM_MULT*ACC_WIDTH: cell `product_acc`
- `out_valid` output 1: captured result available
- `out_ready` input 1: consumer accepts the result
- `out_product` output DIM_MULT*ACC_WIDTH: captured products
- `busy` output 1: high whenever state is not IDLE
- `job_cnt` output 16: count of completed result handshakes; wraps from 0xFFFF to 0

## Operation
- FSM states are IDLE, CLEAR, RUN, SETTLE and DONE. A one-hot or binary encoding is acceptable.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&in_ready`, register both vectors into `cell_input_bin`/`cell_weight_bin`, then go to CLEAR.
- CLEAR: lasts 1 cycle with `cell_rst_n`=0 and `cell_enable`=0, then go to RUN with the counter at 0.
- RUN:
  - `cell_enable`=1 and `cell_rst_n`=1.
  - The counter increments each edge.
  - At the edge where counter equals COMPUTE_CYCLES-1, go to SETTLE and reset the counter to 0.
- SETTLE:
  - `cell_enable`=0.
  - The counter increments each edge.
  - At the edge where counter equals PIPE_LAT-1, register `cell_product` into `out_product` and go to DONE.
- DONE:
  - `out_valid`=1 and `out_product` is held constant.
  - On `out_valid&out_ready`, `job_cnt`+1 (mod 2^16) and go to IDLE.
- Operands stay stable on `cell_*_bin` from acceptance until the next acceptance, including through DONE and IDLE.
- `in_ready` is 0 in every state except IDLE. A new job is never accepted while a result is pending.
- `out_ready` has no effect outside DONE. `in_valid` has no effect outside IDLE.
- `in_ready` must not depend combinationally on `in_valid`. `out_valid` must not depend on `out_ready`.
- The block performs no arithmetic on products; capture is a bit-exact copy.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `in_ready`=1, `cell_rst_n`=0, `cell_enable`=0
  - `cell_input_bin`=0, `cell_weight_bin`=0
  - `out_valid`=0, `out_product`=0, `busy`=0, `job_cnt`=0
- Note that `cell_rst_n` is low during reset, so the cell is held cleared. It is 1 in IDLE after reset.
- Latency, with acceptance at edge E0:
  - CLEAR occupies the cycle after E0.
  - `cell_enable` is high for exactly COMPUTE_CYCLES cycles, starting after E1.
  - Capture happens at edge E(1+COMPUTE_CYCLES+PIPE_LAT).
  - `out_valid` is high from that edge onward. With defaults, that is from E19.
- Best-case job period is 3+COMPUTE_CYCLES+PIPE_LAT cycles, with `out_ready` held high and `in_valid` immediately reasserted.
- Reset asserted mid-job, in any state, immediately forces all reset values. The in-flight job is discarded and `job_cnt` is not incremented.
- `out_ready` held low leaves DONE stable indefinitely. `busy`=1 and `in_ready`=0 throughout.

## Test plan
The bench uses a cell stub whose every product lane equals the number of `enable` cycles since its last clear.

- Reset, then one job with inputs `{9{4'd3}}` and weights `{9{4'd5}}`, `out_ready`=1:
  - `out_valid` rises at E19.
  - Every lane of `out_product` = 16.
  - `job_cnt`=1 afterward.
- Check `cell_enable` during a default job: it is high for exactly 16 consecutive cycles. `cell_rst_n` is low for exactly 1 cycle before them.
- Hold `out_ready`=0 for 40 cycles after `out_valid`, while `in_valid`=1 with new operands:
  - `in_ready` stays 0 and `out_product` is unchanged.
  - The operands are not updated.
  - Releasing `out_ready` returns the block to IDLE, and the new pair is accepted next cycle.
- Back-to-back jobs with inputs `{4'd1..}` then `{4'd8..}`:
  - The second job's `out_product` lanes = 16. The clear worked and nothing accumulated to 32.
  - The period is 21 cycles.
- Assert `rst` during RUN cycle 7:
  - All outputs return to reset values asynchronously.
  - No `out_valid` appears and `job_cnt` stays 0.
- Preload 65535 completed jobs (force the counter) and complete one more: `job_cnt` wraps to 0.
